// File: rtl/piso_serializer.sv
`default_nettype none
// ============================================================================
// Module   : piso_serializer
// Brief    : Parallel-in serial-out transmitter with valid/ready word intake.
// Revision : 1.0  initial release
// ============================================================================
module piso_serializer #(
    parameter int WIDTH     = 4,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             so,
    output logic             so_valid,
    output logic             so_last,
    output logic             busy
);

    localparam int                 c_CNT_W = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_shreg;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_so;
    logic               r_so_valid;
    logic               r_so_last;
    logic               r_busy;

    logic               w_accept;
    logic               w_first;
    logic               w_next;
    logic [WIDTH-1:0]   w_shifted;
    logic [c_CNT_W-1:0] w_cnt_nxt;

    // Ready depends only on registered state (and reset), never on din_valid.
    assign din_ready = ~rst & ((r_state == S_IDLE) | r_so_last);
    assign w_accept  = din_valid & din_ready;

    assign w_first   = LSB_FIRST ? din[0]     : din[WIDTH-1];
    assign w_next    = LSB_FIRST ? r_shreg[1] : r_shreg[WIDTH-2];
    assign w_shifted = LSB_FIRST ? {1'b0, r_shreg[WIDTH-1:1]}
                                 : {r_shreg[WIDTH-2:0], 1'b0};
    assign w_cnt_nxt = r_cnt + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_shreg    <= '0;
            r_cnt      <= '0;
            r_so       <= 1'b0;
            r_so_valid <= 1'b0;
            r_so_last  <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state    <= S_SHIFT;
                        r_shreg    <= din;
                        r_cnt      <= '0;
                        r_so       <= w_first;
                        r_so_valid <= 1'b1;
                        r_so_last  <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (!r_so_last) begin
                        r_shreg   <= w_shifted;
                        r_cnt     <= w_cnt_nxt;
                        r_so      <= w_next;
                        r_so_last <= (w_cnt_nxt == c_LAST);
                    end else if (w_accept) begin
                        // Reload on the final-bit edge so words stream gap-free.
                        r_shreg   <= din;
                        r_cnt     <= '0;
                        r_so      <= w_first;
                        r_so_last <= 1'b0;
                    end else begin
                        r_state    <= S_IDLE;
                        r_shreg    <= '0;
                        r_cnt      <= '0;
                        r_so       <= 1'b0;
                        r_so_valid <= 1'b0;
                        r_so_last  <= 1'b0;
                        r_busy     <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign so       = r_so;
    assign so_valid = r_so_valid;
    assign so_last  = r_so_last;
    assign busy     = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_piso_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_piso_serializer
// Brief    : Directed, table-driven bench for piso_serializer.
// Revision : 1.0  initial release
// ============================================================================
module tb_piso_serializer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Instance A: WIDTH=4, LSB_FIRST=1
    logic [3:0] a_din = '0;
    logic       a_dv  = 1'b0;
    logic       a_rdy, a_so, a_sv, a_sl, a_busy;
    // Instance B: WIDTH=4, LSB_FIRST=0
    logic [3:0] b_din = '0;
    logic       b_dv  = 1'b0;
    logic       b_rdy, b_so, b_sv, b_sl, b_busy;
    // Instance C: WIDTH=8, LSB_FIRST=1
    logic [7:0] c_din = '0;
    logic       c_dv  = 1'b0;
    logic       c_rdy, c_so, c_sv, c_sl, c_busy;

    piso_serializer #(.WIDTH(4), .LSB_FIRST(1'b1)) u_a (
        .clk(clk), .rst(rst), .din(a_din), .din_valid(a_dv), .din_ready(a_rdy),
        .so(a_so), .so_valid(a_sv), .so_last(a_sl), .busy(a_busy));
    piso_serializer #(.WIDTH(4), .LSB_FIRST(1'b0)) u_b (
        .clk(clk), .rst(rst), .din(b_din), .din_valid(b_dv), .din_ready(b_rdy),
        .so(b_so), .so_valid(b_sv), .so_last(b_sl), .busy(b_busy));
    piso_serializer #(.WIDTH(8), .LSB_FIRST(1'b1)) u_c (
        .clk(clk), .rst(rst), .din(c_din), .din_valid(c_dv), .din_ready(c_rdy),
        .so(c_so), .so_valid(c_sv), .so_last(c_sl), .busy(c_busy));

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Per-cycle record: expected outputs seen now, then inputs for the next edge.
    typedef struct {
        logic       so;
        logic       sv;
        logic       sl;
        logic       bz;
        logic       rdy;
        logic       dv;
        logic [3:0] d;
    } vec_t;

    vec_t vec [15];

    initial begin
        //            so    sv    sl    bz    rdy   dv    din
        vec[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b1011}; // idle, offer 1011
        vec[1]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0110}; // bit0
        vec[2]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0110}; // bit1
        vec[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0110}; // bit2
        vec[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'b0110}; // bit3 last, take 0110
        vec[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'b1111}; // stalled din changes
        vec[6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0000};
        vec[7]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'b1111};
        vec[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'b1001}; // last, take 1001
        vec[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000};
        vec[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000};
        vec[11] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000};
        vec[12] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000}; // last, no new word
        vec[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000};
        vec[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000};
    end

    initial begin : main
        logic [3:0] exp_b;
        logic [7:0] exp_c;
        exp_b = 4'b1101;   // sequence 1,0,1,1 indexed by bit position
        exp_c = 8'hA5;     // sequence 1,0,1,0,0,1,0,1 indexed by bit position

        // Reset state
        #2;
        check("rst_ready", a_rdy, 1'b0);
        check("rst_sv", a_sv, 1'b0);
        step();
        step();
        #2 rst = 1'b0;
        #1;
        check("post_rst_ready", a_rdy, 1'b1);
        check("post_rst_busy", a_busy, 1'b0);
        step();

        // Table-driven streaming, back-to-back and stall sequence
        for (int i = 0; i < 15; i++) begin
            check($sformatf("v%0d_so", i), a_so, vec[i].so);
            check($sformatf("v%0d_valid", i), a_sv, vec[i].sv);
            check($sformatf("v%0d_last", i), a_sl, vec[i].sl);
            check($sformatf("v%0d_busy", i), a_busy, vec[i].bz);
            check($sformatf("v%0d_ready", i), a_rdy, vec[i].rdy);
            a_dv  = vec[i].dv;
            a_din = vec[i].d;
            step();
        end

        // Async reset mid-word after two bits of 1011
        a_dv = 1'b1; a_din = 4'b1011;
        step();
        a_dv = 1'b0;
        check("mw_bit0", a_so, 1'b1);
        step();
        check("mw_bit1", a_so, 1'b1);
        #3 rst = 1'b1;
        #1;
        check("mw_rst_so", a_so, 1'b0);
        check("mw_rst_sv", a_sv, 1'b0);
        check("mw_rst_sl", a_sl, 1'b0);
        check("mw_rst_busy", a_busy, 1'b0);
        check("mw_rst_ready", a_rdy, 1'b0);
        a_dv = 1'b1;
        step();
        check("mw_held_ready", a_rdy, 1'b0);
        check("mw_held_sv", a_sv, 1'b0);
        a_dv = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("mw_rel_ready", a_rdy, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("mw_quiet%0d_sv", k), a_sv, 1'b0);
        end
        a_dv = 1'b1; a_din = 4'b0100;
        step();
        a_dv = 1'b0;
        check("mw_new_sv", a_sv, 1'b1);
        check("mw_new_bit0", a_so, 1'b0);
        step();
        check("mw_new_bit1", a_so, 1'b0);
        step();
        check("mw_new_bit2", a_so, 1'b1);
        step();
        check("mw_new_last", a_sl, 1'b1);
        step();
        check("mw_new_idle", a_sv, 1'b0);

        // MSB-first, WIDTH=4
        b_dv = 1'b1; b_din = 4'b1011;
        step();
        b_dv = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("b_bit%0d", k), b_so, exp_b[k]);
            check($sformatf("b_valid%0d", k), b_sv, 1'b1);
            check($sformatf("b_last%0d", k), b_sl, (k == 3));
            step();
        end
        check("b_idle", b_sv, 1'b0);
        check("b_ready", b_rdy, 1'b1);

        // LSB-first, WIDTH=8
        c_dv = 1'b1; c_din = 8'hA5;
        step();
        c_dv = 1'b0;
        for (int k = 0; k < 8; k++) begin
            check($sformatf("c_bit%0d", k), c_so, exp_c[k]);
            check($sformatf("c_valid%0d", k), c_sv, 1'b1);
            check($sformatf("c_last%0d", k), c_sl, (k == 7));
            step();
        end
        check("c_idle", c_sv, 1'b0);
        check("c_busy", c_busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
